// File: rtl/matmul_bram_sequencer.sv
// Read-side sequencer for the matrix-multiply datapath. Walks the output
// matrix C block by block, issuing paired reads to the input and weight
// BRAMs, pacing them against core back-pressure and waiting for the core to
// finish each block before moving on.
module matmul_bram_sequencer #(
    parameter int  BLOCK_SIZE        = 2,
    parameter int  CHUNK_SIZE        = 4,
    parameter int  INNER_DIMENSION   = 4,
    parameter int  W_OUTER_DIMENSION = 6,
    parameter int  I_OUTER_DIMENSION = 6,
    parameter int  ADDR_WIDTH        = 12,
    localparam int KC       = INNER_DIMENSION / CHUNK_SIZE,
    localparam int ROW_C    = I_OUTER_DIMENSION / BLOCK_SIZE,
    localparam int COL_C    = W_OUTER_DIMENSION / BLOCK_SIZE,
    localparam int MAX_FLAG = ROW_C * COL_C,
    localparam int ROW_W    = (ROW_C > 1) ? $clog2(ROW_C) : 1,
    localparam int COL_W    = (COL_C > 1) ? $clog2(COL_C) : 1,
    localparam int FLAG_W   = $clog2(MAX_FLAG + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  ready_o,
    output logic                  done_o,
    input  logic                  core_ready_i,
    input  logic                  core_block_done_i,
    output logic                  in_enb_o,
    output logic [ADDR_WIDTH-1:0] in_addrb_o,
    output logic                  wb_enb_o,
    output logic [ADDR_WIDTH-1:0] wb_addrb_o,
    output logic                  data_valid_o,
    output logic [ROW_W-1:0]      block_row_o,
    output logic [COL_W-1:0]      block_col_o,
    output logic [FLAG_W-1:0]     flag_o
);

    localparam int I_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int K_W = (KC > 1) ? $clog2(KC) : 1;

    localparam logic [I_W-1:0]   I_LAST = I_W'(BLOCK_SIZE - 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(KC - 1);
    localparam logic [ROW_W-1:0] R_LAST = ROW_W'(ROW_C - 1);
    localparam logic [COL_W-1:0] C_LAST = COL_W'(COL_C - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_CORE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  r_q, r_d;
    logic [COL_W-1:0]  c_q, c_d;
    logic [I_W-1:0]    i_q, i_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [FLAG_W-1:0] flag_q, flag_d;
    logic              data_valid_q;

    logic rd_en;
    logic last_read;
    logic last_block;

    // The strobed read is the final one of the block (i and k both at their last value).
    assign last_read  = (i_q == I_LAST) && (k_q == K_LAST);
    // The block being worked on is the bottom-right block of C.
    assign last_block = (r_q == R_LAST) && (c_q == C_LAST);

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only in IDLE, block-done only in WAIT_CORE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start_i) state_d = FETCH;
            FETCH:     if (rd_en && last_read) state_d = WAIT_CORE;
            WAIT_CORE: if (core_block_done_i) state_d = last_block ? DONE : FETCH;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Moore/Mealy outputs: ready in IDLE, done in DONE, read strobe follows core_ready in FETCH.
    always_comb begin
        ready_o = 1'b0;
        done_o  = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE:    ready_o = 1'b1;
            FETCH:   rd_en   = core_ready_i;
            DONE:    done_o  = 1'b1;
            default: ;
        endcase
    end

    // Counter next values: k/i step on each strobed read, r/c/flag step on block completion.
    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        i_d    = i_q;
        k_d    = k_q;
        flag_d = flag_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    r_d    = '0;
                    c_d    = '0;
                    i_d    = '0;
                    k_d    = '0;
                    flag_d = '0;
                end
            end
            FETCH: begin
                if (rd_en) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        i_d = (i_q == I_LAST) ? '0 : i_q + I_W'(1);
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            WAIT_CORE: begin
                if (core_block_done_i) begin
                    flag_d = flag_q + FLAG_W'(1);
                    if (!last_block) begin
                        i_d = '0;
                        k_d = '0;
                        if (c_q == C_LAST) begin
                            c_d = '0;
                            r_d = r_q + ROW_W'(1);
                        end else begin
                            c_d = c_q + COL_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Counter registers and the one-cycle read-latency tracker for data_valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q          <= '0;
            c_q          <= '0;
            i_q          <= '0;
            k_q          <= '0;
            flag_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            r_q          <= r_d;
            c_q          <= c_d;
            i_q          <= i_d;
            k_q          <= k_d;
            flag_q       <= flag_d;
            data_valid_q <= rd_en;
        end
    end

    // Both ports are always read together; the truncating cast keeps the
    // low ADDR_WIDTH bits of the full-width product.
    assign in_enb_o     = rd_en;
    assign wb_enb_o     = rd_en;
    assign in_addrb_o   = ADDR_WIDTH'((32'(r_q) * BLOCK_SIZE + 32'(i_q)) * KC + 32'(k_q));
    assign wb_addrb_o   = ADDR_WIDTH'((32'(c_q) * BLOCK_SIZE + 32'(i_q)) * KC + 32'(k_q));
    assign data_valid_o = data_valid_q;
    assign block_row_o  = r_q;
    assign block_col_o  = c_q;
    assign flag_o       = flag_q;

endmodule

// File: tb/tb_matmul_bram_sequencer.sv
// Self-checking bench for matmul_bram_sequencer. Two instances: defaults
// (KC=1) and INNER_DIMENSION=8 (KC=2). A behavioural model tracks each run as
// a linear strobe count and derives block/row/column/addresses arithmetically.
module tb_matmul_bram_sequencer;

    localparam int BS    = 2;
    localparam int AW    = 12;
    localparam int NBLK  = 9;
    localparam int COLS  = 3;
    localparam int KC_A  = 1;
    localparam int KC_B  = 2;
    localparam int RW    = 2;
    localparam int CW    = 2;
    localparam int FW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s   [2];
    logic          start_s [2];
    logic          cr_s    [2];
    logic          bd_s    [2];
    logic          ready_w [2];
    logic          done_w  [2];
    logic          in_en_w [2];
    logic          wb_en_w [2];
    logic          dv_w    [2];
    logic [AW-1:0] in_ad_w [2];
    logic [AW-1:0] wb_ad_w [2];
    logic [RW-1:0] row_w   [2];
    logic [CW-1:0] col_w   [2];
    logic [FW-1:0] flag_w  [2];

    matmul_bram_sequencer u_a (
        .clk_i(clk), .rst_i(rst_s[0]), .start_i(start_s[0]),
        .ready_o(ready_w[0]), .done_o(done_w[0]),
        .core_ready_i(cr_s[0]), .core_block_done_i(bd_s[0]),
        .in_enb_o(in_en_w[0]), .in_addrb_o(in_ad_w[0]),
        .wb_enb_o(wb_en_w[0]), .wb_addrb_o(wb_ad_w[0]),
        .data_valid_o(dv_w[0]), .block_row_o(row_w[0]),
        .block_col_o(col_w[0]), .flag_o(flag_w[0])
    );

    matmul_bram_sequencer #(.INNER_DIMENSION(8)) u_b (
        .clk_i(clk), .rst_i(rst_s[1]), .start_i(start_s[1]),
        .ready_o(ready_w[1]), .done_o(done_w[1]),
        .core_ready_i(cr_s[1]), .core_block_done_i(bd_s[1]),
        .in_enb_o(in_en_w[1]), .in_addrb_o(in_ad_w[1]),
        .wb_enb_o(wb_en_w[1]), .wb_addrb_o(wb_ad_w[1]),
        .data_valid_o(dv_w[1]), .block_row_o(row_w[1]),
        .block_col_o(col_w[1]), .flag_o(flag_w[1])
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state: 0 idle, 1 fetch, 2 wait-core, 3 done; m_s counts strobes in the run.
    int m_mode [2];
    int m_s    [2];
    int m_flag [2];
    bit m_dv   [2];
    bit m_valid[2];
    bit m_fresh[2];

    int strobe_cnt[2];
    int done_cnt  [2];
    int done_cyc  [2];
    int in_log_a[$];
    int wb_log_a[$];
    int in_log_b[$];
    int wb_log_b[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int kc_of(input int n);
        return (n == 0) ? KC_A : KC_B;
    endfunction

    function automatic int log_at(input int n, input int wb, input int idx);
        if (n == 0) begin
            if (wb != 0) return (idx < wb_log_a.size()) ? wb_log_a[idx] : -1;
            return (idx < in_log_a.size()) ? in_log_a[idx] : -1;
        end
        if (wb != 0) return (idx < wb_log_b.size()) ? wb_log_b[idx] : -1;
        return (idx < in_log_b.size()) ? in_log_b[idx] : -1;
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural model, advanced on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (rst_s[n]) begin
                m_valid[n] = 1'b1;
                m_fresh[n] = 1'b1;
                m_mode[n]  = 0;
                m_s[n]     = 0;
                m_flag[n]  = 0;
                m_dv[n]    = 1'b0;
            end else if (m_valid[n]) begin
                m_dv[n] = (m_mode[n] == 1) && cr_s[n];
                case (m_mode[n])
                    0: if (start_s[n]) begin
                        m_mode[n]  = 1;
                        m_s[n]     = 0;
                        m_flag[n]  = 0;
                        m_fresh[n] = 1'b0;
                    end
                    1: if (cr_s[n]) begin
                        m_s[n]++;
                        if (m_s[n] % (BS * kc_of(n)) == 0) m_mode[n] = 2;
                    end
                    2: if (bd_s[n]) begin
                        m_flag[n]++;
                        m_mode[n] = (m_flag[n] == NBLK) ? 3 : 1;
                    end
                    default: m_mode[n] = 0;
                endcase
            end
        end
    end

    // Compare process: every output of both instances against the model, mid-cycle.
    always @(negedge clk) begin : cmp
        int per, kc, blk, w, ii, kk, exp_en;
        for (int n = 0; n < 2; n++) begin
            if (m_valid[n]) begin
                kc     = kc_of(n);
                per    = BS * kc;
                exp_en = int'((m_mode[n] == 1) && cr_s[n]);
                check($sformatf("u%0d ready", n), int'(ready_w[n]), int'(m_mode[n] == 0));
                check($sformatf("u%0d done", n), int'(done_w[n]), int'(m_mode[n] == 3));
                check($sformatf("u%0d in_enb", n), int'(in_en_w[n]), exp_en);
                check($sformatf("u%0d wb_enb", n), int'(wb_en_w[n]), exp_en);
                check($sformatf("u%0d data_valid", n), int'(dv_w[n]), int'(m_dv[n]));
                check($sformatf("u%0d flag", n), int'(flag_w[n]), m_flag[n]);
                if (m_mode[n] == 1 || m_mode[n] == 2) begin
                    blk = ((m_mode[n] == 2) ? m_s[n] - 1 : m_s[n]) / per;
                    check($sformatf("u%0d block_row", n), int'(row_w[n]), blk / COLS);
                    check($sformatf("u%0d block_col", n), int'(col_w[n]), blk % COLS);
                    if (m_mode[n] == 1) begin
                        w  = m_s[n] % per;
                        ii = w / kc;
                        kk = w % kc;
                        check($sformatf("u%0d in_addrb", n), int'(in_ad_w[n]), ((blk / COLS) * BS + ii) * kc + kk);
                        check($sformatf("u%0d wb_addrb", n), int'(wb_ad_w[n]), ((blk % COLS) * BS + ii) * kc + kk);
                    end
                end
                if (m_fresh[n]) begin
                    check($sformatf("u%0d rst in_addrb", n), int'(in_ad_w[n]), 0);
                    check($sformatf("u%0d rst wb_addrb", n), int'(wb_ad_w[n]), 0);
                    check($sformatf("u%0d rst block_row", n), int'(row_w[n]), 0);
                    check($sformatf("u%0d rst block_col", n), int'(col_w[n]), 0);
                end
            end
            if (in_en_w[n]) begin
                strobe_cnt[n]++;
                if (n == 0) begin
                    in_log_a.push_back(int'(in_ad_w[n]));
                    wb_log_a.push_back(int'(wb_ad_w[n]));
                end else begin
                    in_log_b.push_back(int'(in_ad_w[n]));
                    wb_log_b.push_back(int'(wb_ad_w[n]));
                end
            end
            if (done_w[n]) begin
                done_cnt[n]++;
                done_cyc[n] = cyc;
            end
        end
    end

    // One cycle for instance n: inputs set just after the edge, return at mid-cycle.
    task automatic step(input int n, input int r, input int st, input int cr, input int bd, input int auto_bd);
        @(posedge clk);
        #1;
        rst_s[n]   = (r != 0);
        start_s[n] = (st != 0);
        cr_s[n]    = (cr != 0);
        bd_s[n]    = (bd != 0);
        @(negedge clk);
        if (auto_bd != 0) bd_s[n] = (m_mode[n] == 2);
    endtask

    task automatic clear_logs(input int n);
        strobe_cnt[n] = 0;
        done_cnt[n]   = 0;
        done_cyc[n]   = 0;
        if (n == 0) begin
            in_log_a.delete();
            wb_log_a.delete();
        end else begin
            in_log_b.delete();
            wb_log_b.delete();
        end
    endtask

    // core_ready high, core_block_done pulsed on the first WAIT_CORE cycle, until done.
    task automatic run_auto(input int n, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step(n, 0, 0, 1, 0, 1);
            if (done_w[n]) seen = 1'b1;
        end
        check($sformatf("u%0d run reached done", n), int'(seen), 1);
    endtask

    int first_cyc;

    initial begin
        for (int n = 0; n < 2; n++) begin
            rst_s[n]   = 1'b1;
            start_s[n] = 1'b0;
            cr_s[n]    = 1'b0;
            bd_s[n]    = 1'b0;
        end

        // Reset and release both instances.
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("reset ready", int'(ready_w[0]), 1);
        check("reset done", int'(done_w[0]), 0);
        check("reset in_enb", int'(in_en_w[0]), 0);
        check("reset data_valid", int'(dv_w[0]), 0);
        check("reset in_addrb", int'(in_ad_w[0]), 0);
        check("reset flag", int'(flag_w[0]), 0);

        // Full default run with no stalls.
        clear_logs(0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        first_cyc = cyc;
        check("first strobe enb", int'(in_en_w[0]), 1);
        check("first strobe in", int'(in_ad_w[0]), 0);
        run_auto(0, 60);
        step(0, 0, 0, 1, 0, 0);
        check("run1 back to ready", int'(ready_w[0]), 1);
        check("run1 flag", int'(flag_w[0]), 9);
        check("run1 strobes", strobe_cnt[0], 18);
        check("run1 done pulses", done_cnt[0], 1);
        check("run1 done latency", done_cyc[0] - first_cyc + 1, 28);
        check("blk00 in0", log_at(0, 0, 0), 0);
        check("blk00 in1", log_at(0, 0, 1), 1);
        check("blk00 wb0", log_at(0, 1, 0), 0);
        check("blk00 wb1", log_at(0, 1, 1), 1);
        check("blk01 in0", log_at(0, 0, 2), 0);
        check("blk01 in1", log_at(0, 0, 3), 1);
        check("blk01 wb0", log_at(0, 1, 2), 2);
        check("blk01 wb1", log_at(0, 1, 3), 3);
        check("blk22 in0", log_at(0, 0, 16), 4);
        check("blk22 in1", log_at(0, 0, 17), 5);
        check("blk22 wb0", log_at(0, 1, 16), 4);
        check("blk22 wb1", log_at(0, 1, 17), 5);

        // core_block_done in IDLE is ignored.
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        check("idle block_done flag", int'(flag_w[0]), 9);
        check("idle block_done ready", int'(ready_w[0]), 1);

        // Stall after the first strobe, stray start/block_done, long block_done.
        clear_logs(0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("stall first enb", int'(in_en_w[0]), 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0);
            check("stall enb", int'(in_en_w[0]), 0);
            check("stall in hold", int'(in_ad_w[0]), 1);
            check("stall wb hold", int'(wb_ad_w[0]), 1);
            check("stall dv", int'(dv_w[0]), (k == 0) ? 1 : 0);
        end
        step(0, 0, 0, 1, 0, 0);
        check("resume enb", int'(in_en_w[0]), 1);
        check("resume in", int'(in_ad_w[0]), 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1, 0);
        check("fetch block_done flag", int'(flag_w[0]), 1);
        step(0, 0, 1, 1, 1, 0);
        check("midrun start ignored", int'(ready_w[0]), 0);
        step(0, 0, 0, 1, 1, 0);
        check("wait flag before", int'(flag_w[0]), 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0);
        check("held block_done flag", int'(flag_w[0]), 2);
        check("held block_done col", int'(col_w[0]), 2);
        check("held block_done enb", int'(in_en_w[0]), 0);
        run_auto(0, 60);
        step(0, 0, 0, 1, 0, 0);
        check("run2 flag", int'(flag_w[0]), 9);
        check("run2 strobes", strobe_cnt[0], 18);
        check("run2 done pulses", done_cnt[0], 1);
        check("run2 in2", log_at(0, 0, 2), 0);
        check("run2 in3", log_at(0, 0, 3), 1);
        check("run2 wb3", log_at(0, 1, 3), 3);
        check("run2 wb4", log_at(0, 1, 4), 4);

        // Reset in FETCH of block (1,2), then restart; start+rst together.
        clear_logs(0);
        step(0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 15; k++) step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        check("blk12 row", int'(row_w[0]), 1);
        check("blk12 col", int'(col_w[0]), 2);
        check("blk12 in", int'(in_ad_w[0]), 2);
        check("blk12 wb", int'(wb_ad_w[0]), 4);
        check("blk12 flag", int'(flag_w[0]), 5);
        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("after rst ready", int'(ready_w[0]), 1);
        check("after rst enb", int'(in_en_w[0]), 0);
        check("after rst dv", int'(dv_w[0]), 0);
        check("after rst flag", int'(flag_w[0]), 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("restart in", int'(in_ad_w[0]), 0);
        check("restart wb", int'(wb_ad_w[0]), 0);
        check("restart enb", int'(in_en_w[0]), 1);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("rst+start fetch ready", int'(ready_w[0]), 1);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("rst+start idle ready", int'(ready_w[0]), 1);
        check("rst+start idle enb", int'(in_en_w[0]), 0);

        // KC=2 instance: four reads per block.
        clear_logs(1);
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0, 1);
        first_cyc = cyc;
        check("kc2 first enb", int'(in_en_w[1]), 1);
        step(1, 0, 0, 1, 0, 1);
        check("kc2 dv trails", int'(dv_w[1]), 1);
        check("kc2 second in", int'(in_ad_w[1]), 1);
        run_auto(1, 120);
        step(1, 0, 0, 1, 0, 0);
        check("kc2 strobes", strobe_cnt[1], 36);
        check("kc2 flag", int'(flag_w[1]), 9);
        check("kc2 done latency", done_cyc[1] - first_cyc + 1, 46);
        for (int k = 0; k < 4; k++) begin
            check("kc2 blk10 in", log_at(1, 0, 12 + k), 4 + k);
            check("kc2 blk10 wb", log_at(1, 1, 12 + k), k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
